// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcodes, bubble encoding
// and instruction field positions.
package mips_pkg;

  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101;

  localparam logic [31:0] NOP_INSTR = 32'h0;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

endpackage

// File: rtl/hazard_unit.sv
// Decode-stage hazard detection and branch operand
// forwarding selects; purely combinational.
module hazard_unit #(
  parameter int REG_AW = 5
) (
  input  logic              validD,
  input  logic              branchD,
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic              RegWriteE,
  input  logic              MemtoRegE,
  input  logic [REG_AW-1:0] WriteRegE,
  input  logic              RegWriteM,
  input  logic              MemtoRegM,
  input  logic [REG_AW-1:0] WriteRegM,
  output logic              fwd_a,
  output logic              fwd_b,
  output logic              hazard
);

  logic e_hit;
  logic m_hit;
  logic lwstall;
  logic brstall;

  always_comb begin
    e_hit = (WriteRegE != '0)
          & ((WriteRegE == rsD) | (WriteRegE == rtD));
    m_hit = (WriteRegM != '0)
          & ((WriteRegM == rsD) | (WriteRegM == rtD));

    fwd_a = RegWriteM & (rsD != '0) & (rsD == WriteRegM);
    fwd_b = RegWriteM & (rtD != '0) & (rtD == WriteRegM);

    lwstall = validD & MemtoRegE & e_hit;
    // Branch compares in D, so any pending EX result or MEM load
    // feeding it is not yet forwardable.
    brstall = branchD
            & ((RegWriteE & e_hit) | (MemtoRegM & m_hit));
    hazard  = lwstall | brstall;
  end

endmodule

// File: rtl/decode_branch_resolve.sv
// IF/ID register with early BEQ/BNE resolution, hazard
// stall generation and saturating event counters.
module decode_branch_resolve
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] PC,
  input  logic [DATA_W-1:0] instruction,
  input  logic [DATA_W-1:0] RD1D,
  input  logic [DATA_W-1:0] RD2D,
  input  logic [DATA_W-1:0] ALUOutM,
  input  logic              RegWriteE,
  input  logic              MemtoRegE,
  input  logic [REG_AW-1:0] WriteRegE,
  input  logic              RegWriteM,
  input  logic              MemtoRegM,
  input  logic [REG_AW-1:0] WriteRegM,
  output logic [DATA_W-1:0] instrD,
  output logic [DATA_W-1:0] PCplus4D,
  output logic              validD,
  output logic [REG_AW-1:0] rsD,
  output logic [REG_AW-1:0] rtD,
  output logic [DATA_W-1:0] PCbranchD,
  output logic              PCSrcD,
  output logic              hazardDetected,
  output logic              FlushE,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  taken_cnt
);

  logic [DATA_W-1:0] instr_q, instr_d;
  logic [DATA_W-1:0] pc4_q, pc4_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  taken_q, taken_d;

  logic [5:0]        op;
  logic              is_beq;
  logic              is_bne;
  logic              branch;
  logic              fwd_a;
  logic              fwd_b;
  logic              hazard;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic              cond;
  logic [DATA_W-1:0] offset;

  assign op     = instr_q[OP_HI:OP_LO];
  assign is_beq = (op == OP_BEQ);
  assign is_bne = (op == OP_BNE);
  assign branch = valid_q & (is_beq | is_bne);

  assign instrD   = instr_q;
  assign PCplus4D = pc4_q;
  assign validD   = valid_q;
  assign rsD      = instr_q[RS_HI:RS_LO];
  assign rtD      = instr_q[RT_HI:RT_LO];

  hazard_unit #(
    .REG_AW (REG_AW)
  ) u_hazard (
    .validD    (valid_q),
    .branchD   (branch),
    .rsD       (rsD),
    .rtD       (rtD),
    .RegWriteE (RegWriteE),
    .MemtoRegE (MemtoRegE),
    .WriteRegE (WriteRegE),
    .RegWriteM (RegWriteM),
    .MemtoRegM (MemtoRegM),
    .WriteRegM (WriteRegM),
    .fwd_a     (fwd_a),
    .fwd_b     (fwd_b),
    .hazard    (hazard)
  );

  assign opa  = fwd_a ? ALUOutM : RD1D;
  assign opb  = fwd_b ? ALUOutM : RD2D;
  assign cond = is_beq ? (opa == opb) : (opa != opb);

  assign offset = {{(DATA_W-18){instr_q[IMM_HI]}},
                   instr_q[IMM_HI:IMM_LO], 2'b00};

  assign PCbranchD      = pc4_q + offset;
  assign PCSrcD         = branch & cond & ~hazard;
  assign hazardDetected = hazard;
  assign FlushE         = hazard;
  assign stall_cnt      = stall_q;
  assign taken_cnt      = taken_q;

  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    stall_d = stall_q;
    taken_d = taken_q;

    unique case (1'b1)
      hazard: ;
      PCSrcD: begin
        instr_d = DATA_W'(NOP_INSTR);
        pc4_d   = '0;
        valid_d = 1'b0;
      end
      default: begin
        instr_d = instruction;
        pc4_d   = PC + DATA_W'(4);
        valid_d = 1'b1;
      end
    endcase

    if (hazard && (stall_q != '1)) stall_d = stall_q + 1'b1;
    if (PCSrcD && (taken_q != '1)) taken_d = taken_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      stall_q <= '0;
      taken_q <= '0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      stall_q <= stall_d;
      taken_q <= taken_d;
    end
  end

endmodule
